seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width; only 32 is required to be supported.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit, request to begin a division.
REQ-005 The block SHALL have port is_signed, input, 1 bit: 1 for two's-complement operands, 0 for unsigned.
REQ-006 The block SHALL have port dividend, input, 32 bits.
REQ-007 The block SHALL have port divisor, input, 32 bits.
REQ-008 The block SHALL have port busy, output, 1 bit, high while a division is in progress.
REQ-009 The block SHALL have port done, output, 1 bit, a single-cycle pulse when results become valid.
REQ-010 The block SHALL have port quotient, output, 32 bits.
REQ-011 The block SHALL have port remainder, output, 32 bits.
REQ-012 The block SHALL have port div_by_zero, output, 1 bit, valid with done.

Function
REQ-013 The FSM SHALL have states IDLE, RUN, FIX and DONE.
REQ-014 In IDLE or DONE, start=1 SHALL latch is_signed, dividend and divisor, clear the iteration counter and enter RUN; in every other state start SHALL be ignored.
REQ-015 In signed mode, operands SHALL be converted to magnitudes at latch time, and the sign flags SHALL be recorded.
REQ-016 RUN SHALL last exactly 32 cycles, each executing one restoring step on a 64-bit {remainder, quotient} register: shift left by 1; if upper half >= divisor magnitude, subtract it and set quotient LSB to 1.
REQ-017 After the 32nd RUN cycle the FSM SHALL enter FIX, which applies sign correction: quotient is negated when the operand signs differ, and remainder takes the sign of the dividend.
REQ-018 FIX SHALL be followed by DONE for exactly one cycle, with done=1 in that cycle; DONE then returns to IDLE unless start=1.
REQ-019 Latency SHALL be fixed: done is observed exactly 34 cycles after the clock edge that accepted start, for all operands including divide-by-zero.
REQ-020 busy SHALL be 1 in RUN and FIX, and 0 in IDLE and DONE.
REQ-021 quotient and remainder SHALL be valid from DONE onward and SHALL hold until the next accepted start; during RUN/FIX their values are don't-care.
REQ-022 When divisor = 0, the result SHALL be quotient = 0xFFFFFFFF, remainder = dividend (original, unsigned-interpreted bits) and div_by_zero = 1, in both modes.
REQ-023 A signed division of 0x80000000 by 0xFFFFFFFF SHALL produce quotient 0x80000000, remainder 0, div_by_zero = 0.
REQ-024 div_by_zero SHALL be cleared on each accepted start.

Reset
REQ-025 Asserting rst at any time, including mid-RUN, SHALL immediately force IDLE, busy=0, done=0, div_by_zero=0, quotient=0, remainder=0, counter=0, and clear all operand registers.
REQ-026 After rst deasserts, the first rising edge with start=1 SHALL be accepted normally.

Structure
REQ-027 A shared package SHALL hold the state enumeration, the width constant 32 and the iteration-count constant 32.
REQ-028 One combinational sub-module, div_step, SHALL implement a single shift-compare-subtract iteration (64-bit in, divisor in, 64-bit out).
REQ-029 Sign handling and control SHALL reside in seq_divider; the target implementation size is 150-300 lines.

Verification
REQ-030 Unsigned 100 / 7 SHALL give quotient 14, remainder 2, done exactly 34 cycles after start, with busy high for the intervening 33 cycles.
REQ-031 Signed -7 / 2 (0xFFFFFFF9 / 0x2) SHALL give quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; unsigned 0x80000000 / 0xFFFFFFFF SHALL give quotient 0, remainder 0x80000000.
REQ-032 Divide-by-zero, 0x1234 / 0 in either mode, SHALL give quotient 0xFFFFFFFF, remainder 0x1234, div_by_zero=1 at 34 cycles.
REQ-033 Signed 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000, remainder 0.
REQ-034 When start is pulsed with new operands during RUN, that start SHALL be ignored and the original result SHALL be returned; a start in the DONE cycle SHALL begin a back-to-back division with done 34 cycles later.
REQ-035 When rst is asserted at RUN cycle 10, all outputs SHALL read 0 immediately, no done pulse SHALL occur, and a subsequent start SHALL complete correctly.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared constants and FSM state encoding for the sequential restoring divider.
package seq_divider_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITERS = 32;
  localparam int CNT_W     = $clog2(DIV_ITERS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift {rem, quo} left, then conditionally
// subtract the divisor from the upper half and set the quotient LSB.
module div_step
  import seq_divider_pkg::*;
#(
  parameter int W = DIV_WIDTH
) (
  input  logic [2*W-1:0] acc_in,
  input  logic [W-1:0]   dvs,
  output logic [2*W-1:0] acc_out
);

  logic [2*W-1:0] shifted;
  logic [W:0]     diff;

  always_comb begin
    shifted = {acc_in[2*W-2:0], 1'b0};
    // The bit shifted out of the top takes part in the compare so that a
    // partial remainder above 2^(W-1) can never wrap.
    diff    = {acc_in[2*W-1], shifted[2*W-1:W]} - {1'b0, dvs};
    acc_out = shifted;
    if (!diff[W]) begin
      acc_out[2*W-1:W] = diff[W-1:0];
      acc_out[0]       = 1'b1;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Fixed-latency signed/unsigned 32-bit sequential divider: 32 restoring steps,
// one sign-fix cycle, then a single-cycle done pulse.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output div_state_e       dbg_state
);

  // Handshake: start is sampled on every rising edge but only accepted while
  // idle or in the done cycle; done is a one-cycle pulse, busy covers RUN+FIX.
  div_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q, acc_step;
  logic [WIDTH-1:0]   dvs_q;
  logic [WIDTH-1:0]   dividend_q;
  logic               neg_quo_q;
  logic               neg_rem_q;
  logic               accept;
  logic               last_iter;
  logic [WIDTH-1:0]   dividend_mag;
  logic [WIDTH-1:0]   divisor_mag;
  logic [WIDTH-1:0]   quo_raw, rem_raw;
  logic               dividend_neg, divisor_neg;

  assign accept    = start && (state_q == S_IDLE || state_q == S_DONE);
  assign last_iter = (cnt_q == CNT_W'(DIV_ITERS - 1));

  assign dividend_neg = is_signed && dividend[WIDTH-1];
  assign divisor_neg  = is_signed && divisor[WIDTH-1];
  assign dividend_mag = dividend_neg ? (~dividend + 1'b1) : dividend;
  assign divisor_mag  = divisor_neg  ? (~divisor + 1'b1)  : divisor;

  assign quo_raw = acc_q[WIDTH-1:0];
  assign rem_raw = acc_q[2*WIDTH-1:WIDTH];

  div_step #(.W(WIDTH)) u_step (
    .acc_in  (acc_q),
    .dvs     (dvs_q),
    .acc_out (acc_step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (last_iter) state_d = S_FIX;
      end
      S_FIX: begin
        busy    = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = start ? S_RUN : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dbg_state = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      dvs_q       <= '0;
      dividend_q  <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      cnt_q       <= '0;
      acc_q       <= {{WIDTH{1'b0}}, dividend_mag};
      dvs_q       <= divisor_mag;
      dividend_q  <= dividend;
      neg_quo_q   <= dividend_neg ^ divisor_neg;
      neg_rem_q   <= dividend_neg;
      div_by_zero <= 1'b0;
    end else if (state_q == S_RUN) begin
      acc_q <= acc_step;
      cnt_q <= cnt_q + 1'b1;
    end else if (state_q == S_FIX) begin
      // A zero divisor reports the raw dividend bits regardless of mode.
      if (dvs_q == '0) begin
        quotient    <= '1;
        remainder   <= dividend_q;
        div_by_zero <= 1'b1;
      end else begin
        quotient    <= neg_quo_q ? (~quo_raw + 1'b1) : quo_raw;
        remainder   <= neg_rem_q ? (~rem_raw + 1'b1) : rem_raw;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider: latency, sign handling, divide-by-zero,
// ignored starts, back-to-back operation and asynchronous reset.
module tb_seq_divider;
  import seq_divider_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;
  div_state_e  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  seq_divider dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  // Presents operands for one rising edge; returns 1 time unit after that edge.
  task automatic pulse_start(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts cycles (the cycle right after the accepting edge is cycle 1) until done.
  task automatic wait_done(output int cycles);
    cycles = 1;
    while (done !== 1'b1 && cycles < 60) begin
      @(posedge clk);
      #1 cycles++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 32'h0 || remainder !== 32'h0
        || dbg_state !== S_IDLE) begin
      n_errors++;
      $display("FAIL reset_state: busy=%b done=%b dbz=%b q=%h r=%h st=%0d, want all 0 / IDLE",
               busy, done, div_by_zero, quotient, remainder, dbg_state);
    end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_unsigned_latency;
    int busy_bad;
    busy_bad = 0;
    pulse_start(1'b0, 32'd100, 32'd7);
    for (int k = 1; k <= 33; k++) begin
      if (busy !== 1'b1 || done !== 1'b0) busy_bad++;
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (busy_bad != 0) begin
      n_errors++;
      $display("FAIL u100_7_busy: %0d of 33 cycles had busy!=1 or done!=0, want 0", busy_bad);
    end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL u100_7_done34: done=%b busy=%b in cycle 34, want 1/0", done, busy);
    end
    n_checks++;
    if (quotient !== 32'd14 || remainder !== 32'd2 || div_by_zero !== 1'b0) begin
      n_errors++;
      $display("FAIL u100_7_result: q=%h r=%h dbz=%b, want 0000000e 00000002 0",
               quotient, remainder, div_by_zero);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0 || quotient !== 32'd14 || dbg_state !== S_IDLE) begin
      n_errors++;
      $display("FAIL u100_7_hold: done=%b q=%h st=%0d, want 0 0000000e IDLE",
               done, quotient, dbg_state);
    end
  endtask

  task automatic test_signs;
    logic        sg [6];
    logic [31:0] a  [6];
    logic [31:0] b  [6];
    logic [31:0] eq [6];
    logic [31:0] er [6];
    int cyc;
    sg[0] = 1'b1; a[0] = 32'hFFFFFFF9; b[0] = 32'h2;        eq[0] = 32'hFFFFFFFD; er[0] = 32'hFFFFFFFF;
    sg[1] = 1'b0; a[1] = 32'h80000000; b[1] = 32'hFFFFFFFF; eq[1] = 32'h0;        er[1] = 32'h80000000;
    sg[2] = 1'b1; a[2] = 32'h80000000; b[2] = 32'hFFFFFFFF; eq[2] = 32'h80000000; er[2] = 32'h0;
    sg[3] = 1'b1; a[3] = 32'd100;      b[3] = 32'hFFFFFFF9; eq[3] = 32'hFFFFFFF2; er[3] = 32'd2;
    sg[4] = 1'b1; a[4] = 32'hFFFFFF9C; b[4] = 32'hFFFFFFF9; eq[4] = 32'd14;       er[4] = 32'hFFFFFFFE;
    sg[5] = 1'b0; a[5] = 32'hFFFFFFFF; b[5] = 32'hFFFFFFFE; eq[5] = 32'd1;        er[5] = 32'd1;
    for (int i = 0; i < 6; i++) begin
      pulse_start(sg[i], a[i], b[i]);
      wait_done(cyc);
      n_checks++;
      if (cyc != 34 || quotient !== eq[i] || remainder !== er[i] || div_by_zero !== 1'b0) begin
        n_errors++;
        $display("FAIL signs_%0d: cyc=%0d q=%h r=%h dbz=%b, want 34 %h %h 0",
                 i, cyc, quotient, remainder, div_by_zero, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_div_by_zero;
    logic        sg [3];
    logic [31:0] a  [3];
    int cyc;
    sg[0] = 1'b0; a[0] = 32'h1234;
    sg[1] = 1'b1; a[1] = 32'h1234;
    sg[2] = 1'b1; a[2] = 32'hFFFFFFF9;
    for (int i = 0; i < 3; i++) begin
      pulse_start(sg[i], a[i], 32'h0);
      wait_done(cyc);
      n_checks++;
      if (cyc != 34 || quotient !== 32'hFFFFFFFF || remainder !== a[i] || div_by_zero !== 1'b1) begin
        n_errors++;
        $display("FAIL dbz_%0d: cyc=%0d q=%h r=%h dbz=%b, want 34 ffffffff %h 1",
                 i, cyc, quotient, remainder, div_by_zero, a[i]);
      end
    end
    // The next accepted start must clear the flag.
    pulse_start(1'b0, 32'd9, 32'd3);
    n_checks++;
    if (div_by_zero !== 1'b0) begin
      n_errors++;
      $display("FAIL dbz_clear: dbz=%b after accepted start, want 0", div_by_zero);
    end
    wait_done(cyc);
    n_checks++;
    if (cyc != 34 || quotient !== 32'd3 || remainder !== 32'd0) begin
      n_errors++;
      $display("FAIL u9_3: cyc=%0d q=%h r=%h, want 34 00000003 00000000", cyc, quotient, remainder);
    end
  endtask

  task automatic test_start_ignored;
    int cyc;
    pulse_start(1'b0, 32'd100, 32'd7);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    pulse_start(1'b1, 32'd50, 32'd5);
    wait_done(cyc);
    n_checks++;
    if (cyc != 28 || quotient !== 32'd14 || remainder !== 32'd2) begin
      n_errors++;
      $display("FAIL start_ignored: cyc=%0d q=%h r=%h, want 28 0000000e 00000002",
               cyc, quotient, remainder);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    pulse_start(1'b0, 32'd1000, 32'd33);
    wait_done(cyc);
    n_checks++;
    if (cyc != 34 || quotient !== 32'd30 || remainder !== 32'd10) begin
      n_errors++;
      $display("FAIL b2b_first: cyc=%0d q=%h r=%h, want 34 0000001e 0000000a", cyc, quotient, remainder);
    end
    // Still inside the DONE cycle: this start must be accepted.
    pulse_start(1'b1, 32'hFFFFFC18, 32'd33);
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_accept: busy=%b done=%b, want 1 0", busy, done);
    end
    wait_done(cyc);
    n_checks++;
    if (cyc != 34 || quotient !== 32'hFFFFFFE2 || remainder !== 32'hFFFFFFF6) begin
      n_errors++;
      $display("FAIL b2b_second: cyc=%0d q=%h r=%h, want 34 ffffffe2 fffffff6", cyc, quotient, remainder);
    end
  endtask

  task automatic test_reset_mid_run;
    int cyc;
    int done_seen;
    pulse_start(1'b0, 32'd77, 32'd5);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 32'h0 || remainder !== 32'h0
        || dbg_state !== S_IDLE) begin
      n_errors++;
      $display("FAIL rst_mid_run: busy=%b done=%b dbz=%b q=%h r=%h st=%0d, want all 0 / IDLE",
               busy, done, div_by_zero, quotient, remainder, dbg_state);
    end
    @(negedge clk) rst = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) done_seen++;
    end
    n_checks++;
    if (done_seen != 0) begin
      n_errors++;
      $display("FAIL rst_no_done: %0d cycles with done/busy set after reset, want 0", done_seen);
    end
    pulse_start(1'b0, 32'd77, 32'd5);
    wait_done(cyc);
    n_checks++;
    if (cyc != 34 || quotient !== 32'd15 || remainder !== 32'd2) begin
      n_errors++;
      $display("FAIL rst_recover: cyc=%0d q=%h r=%h, want 34 0000000f 00000002", cyc, quotient, remainder);
    end
  endtask

  initial begin
    test_reset;
    test_unsigned_latency;
    test_signs;
    test_div_by_zero;
    test_start_ignored;
    test_back_to_back;
    test_reset_mid_run;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
